// File: rtl/log2_req_scheduler_pkg.sv
// Shared state encoding and sizing helpers for the log2 request scheduler.
// Imported by the scheduler top and its tag FIFO.
package log2_req_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  localparam int N_REQ_DEFAULT = 4;
  localparam int TAG_W_DEFAULT = clog2(N_REQ_DEFAULT);

endpackage

// File: rtl/log2_tag_fifo.sv
// Show-ahead FIFO holding requester IDs in issue order; dout_o is the oldest tag while !empty_o.
// One-cycle write-to-visible latency; pushes when full and pops when empty are ignored.
module log2_tag_fifo
  import log2_req_scheduler_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = TAG_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= bump(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= bump(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/log2_req_scheduler.sv
// Round-robin scheduler sharing one fixed-latency fast_log2 pipeline; optional stats ports via LOG2_SCHED_STATS_EN.
// Request->log_valid and log_rdy->resp_valid are one cycle each; issue stalls when credits run out, responses are never stalled.
module log2_req_scheduler
  import log2_req_scheduler_pkg::*;
#(
  parameter int N_REQ        = N_REQ_DEFAULT,
  parameter int FP_SIZE      = 32,
  parameter int PIPE_LATENCY = 48,
  parameter int TAG_DEPTH    = 64
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*FP_SIZE-1:0] req_x,
  output logic [N_REQ-1:0]         req_ack,
  output logic                     log_valid,
  output logic [FP_SIZE-1:0]       log_x,
  input  logic                     log_rdy,
  input  logic [FP_SIZE-1:0]       log_result,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [FP_SIZE-1:0]       resp_result,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     err_underflow
`ifdef LOG2_SCHED_STATS_EN
  ,
  output logic [N_REQ*16-1:0]             stat_count,
  output logic [clog2(TAG_DEPTH+1)-1:0]   stat_max_outstanding
`endif
);

  localparam int TAG_W = clog2(N_REQ);
  localparam int CNT_W = clog2(TAG_DEPTH + 1);
  localparam int FL_W  = clog2(PIPE_LATENCY + 1);

  sched_state_e       state_q;
  logic [FL_W-1:0]    flush_cnt_q;
  logic [TAG_W-1:0]   rr_q;
  logic [TAG_W-1:0]   rr_d;
  logic [CNT_W-1:0]   outstanding_q;
  logic [CNT_W-1:0]   outstanding_d;
  logic [N_REQ-1:0]   req_ack_q;
  logic [N_REQ-1:0]   resp_valid_q;
  logic               log_valid_q;
  logic               drain_done_q;
  logic               err_underflow_q;
  logic [FP_SIZE-1:0] log_x_q;
  logic [FP_SIZE-1:0] resp_result_q;

  logic [N_REQ-1:0]   eligible;
  logic [TAG_W-1:0]   winner;
  logic               any_elig;
  logic               issue;
  logic               routing;
  logic               pop;
  logic               tag_empty;
  logic               tag_full;
  logic [TAG_W-1:0]   tag_head;

  function automatic logic [TAG_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return TAG_W'((s >= N_REQ) ? s - N_REQ : s);
  endfunction

  // Masking with the ack just sent stops a second grant while the requester drops valid.
  assign eligible = req_valid & ~req_ack_q;
  assign routing  = (state_q != ST_FLUSH);
  assign issue    = (state_q == ST_RUN) && any_elig &&
                    (outstanding_q < CNT_W'(TAG_DEPTH)) && !tag_full;
  assign pop      = routing && log_rdy && !tag_empty;
  assign rr_d     = (winner == TAG_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

  // Scan from the far end so the index nearest the pointer is the last to overwrite.
  always_comb begin
    winner   = rr_q;
    any_elig = 1'b0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (eligible[wrap_idx(int'(rr_q), off)]) begin
        winner   = wrap_idx(int'(rr_q), off);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !pop) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (pop && !issue) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  log2_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (issue),
    .pop_i   (pop),
    .din_i   (winner),
    .dout_o  (tag_head),
    .empty_o (tag_empty),
    .full_o  (tag_full)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= ST_FLUSH;
      flush_cnt_q     <= '0;
      rr_q            <= '0;
      outstanding_q   <= '0;
      req_ack_q       <= '0;
      log_valid_q     <= 1'b0;
      log_x_q         <= '0;
      resp_valid_q    <= '0;
      resp_result_q   <= '0;
      drain_done_q    <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      log_valid_q   <= issue;
      req_ack_q     <= issue ? (N_REQ'(1) << winner) : '0;
      if (issue) begin
        log_x_q <= req_x[winner*FP_SIZE +: FP_SIZE];
        rr_q    <= rr_d;
      end
      resp_valid_q <= pop ? (N_REQ'(1) << tag_head) : '0;
      if (pop) resp_result_q <= log_result;
      if (routing && log_rdy && tag_empty) err_underflow_q <= 1'b1;

      case (state_q)
        // Results still in the datapath from before reset arrive here and are dropped.
        ST_FLUSH: begin
          if (flush_cnt_q == FL_W'(PIPE_LATENCY - 1)) state_q <= ST_RUN;
          else flush_cnt_q <= flush_cnt_q + 1'b1;
        end
        ST_RUN: begin
          drain_done_q <= 1'b0;
          if (drain_req) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!drain_req && outstanding_q == '0) begin
            state_q      <= ST_RUN;
            drain_done_q <= 1'b0;
          end else begin
            drain_done_q <= (outstanding_q == '0);
          end
        end
        default: state_q <= ST_FLUSH;
      endcase
    end
  end

  assign req_ack       = req_ack_q;
  assign log_valid     = log_valid_q;
  assign log_x         = log_x_q;
  assign resp_valid    = resp_valid_q;
  assign resp_result   = resp_result_q;
  assign drain_done    = drain_done_q;
  assign err_underflow = err_underflow_q;

`ifdef LOG2_SCHED_STATS_EN
  logic [N_REQ*16-1:0] stat_count_q;
  logic [CNT_W-1:0]    stat_max_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stat_count_q <= '0;
      stat_max_q   <= '0;
    end else begin
      if (issue && stat_count_q[winner*16 +: 16] != 16'hFFFF) begin
        stat_count_q[winner*16 +: 16] <= stat_count_q[winner*16 +: 16] + 16'd1;
      end
      if (outstanding_d > stat_max_q) stat_max_q <= outstanding_d;
    end
  end

  assign stat_count           = stat_count_q;
  assign stat_max_outstanding = stat_max_q;
`endif

endmodule

// File: tb/tb_log2_req_scheduler.sv
// Directed bench: a default scheduler plus a TAG_DEPTH=4 copy, each fed by a 48-cycle log2 pipeline model.
module tb_log2_req_scheduler;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [N-1:0]   req_valid, req_ack, resp_valid;
  logic [N*W-1:0] req_x;
  logic           log_valid, log_rdy, drain_req, drain_done, err_underflow;
  logic [W-1:0]   log_x, log_result, resp_result;
  logic           inj_rdy;

  logic [N-1:0]   req_valid_s, req_ack_s, resp_valid_s;
  logic [N*W-1:0] req_x_s;
  logic           log_valid_s, log_rdy_s, drain_req_s, drain_done_s, err_underflow_s;
  logic [W-1:0]   log_x_s, log_result_s, resp_result_s;

`ifdef LOG2_SCHED_STATS_EN
  logic [N*16-1:0] stat_count, stat_count_s;
  logic [6:0]      stat_max;
  logic [2:0]      stat_max_s;
`endif

  logic [W-1:0] xop  [N];
  logic [W-1:0] yexp [N];

  function automatic logic [W-1:0] log2_model(input logic [W-1:0] x);
    case (x)
      32'h4000_0000: return 32'h3F80_0000;
      32'h4080_0000: return 32'h4000_0000;
      32'h4100_0000: return 32'h4040_0000;
      32'h4180_0000: return 32'h4080_0000;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Pipeline models: no reset and no stall, so results issued before a reset still emerge.
  logic [LAT-1:0] pv_m = '0;
  logic [LAT-1:0] pv_s = '0;
  logic [W-1:0]   px_m [LAT];
  logic [W-1:0]   px_s [LAT];

  always @(posedge clk) begin
    pv_m     <= {pv_m[LAT-2:0], log_valid === 1'b1};
    px_m[0]  <= log2_model(log_x);
    for (int k = 1; k < LAT; k++) px_m[k] <= px_m[k-1];
  end

  always @(posedge clk) begin
    pv_s     <= {pv_s[LAT-2:0], log_valid_s === 1'b1};
    px_s[0]  <= log2_model(log_x_s);
    for (int k = 1; k < LAT; k++) px_s[k] <= px_s[k-1];
  end

  assign log_rdy      = pv_m[LAT-1] | inj_rdy;
  assign log_result   = px_m[LAT-1];
  assign log_rdy_s    = pv_s[LAT-1];
  assign log_result_s = px_s[LAT-1];

  log2_req_scheduler u_dut (
    .CLK           (clk),
    .RESET         (rst),
    .req_valid     (req_valid),
    .req_x         (req_x),
    .req_ack       (req_ack),
    .log_valid     (log_valid),
    .log_x         (log_x),
    .log_rdy       (log_rdy),
    .log_result    (log_result),
    .resp_valid    (resp_valid),
    .resp_result   (resp_result),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .err_underflow (err_underflow)
`ifdef LOG2_SCHED_STATS_EN
    ,
    .stat_count           (stat_count),
    .stat_max_outstanding (stat_max)
`endif
  );

  log2_req_scheduler #(.TAG_DEPTH(4)) u_dut_small (
    .CLK           (clk),
    .RESET         (rst),
    .req_valid     (req_valid_s),
    .req_x         (req_x_s),
    .req_ack       (req_ack_s),
    .log_valid     (log_valid_s),
    .log_x         (log_x_s),
    .log_rdy       (log_rdy_s),
    .log_result    (log_result_s),
    .resp_valid    (resp_valid_s),
    .resp_result   (resp_result_s),
    .drain_req     (drain_req_s),
    .drain_done    (drain_done_s),
    .err_underflow (err_underflow_s)
`ifdef LOG2_SCHED_STATS_EN
    ,
    .stat_count           (stat_count_s),
    .stat_max_outstanding (stat_max_s)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    int         n_resp, n_rdy, got, ea;
    logic       bad, bad2;
    logic [N-1:0] rv;
    logic [W-1:0] rres;

    xop[0] = 32'h4000_0000; xop[1] = 32'h4080_0000;
    xop[2] = 32'h4100_0000; xop[3] = 32'h4180_0000;
    yexp[0] = 32'h3F80_0000; yexp[1] = 32'h4000_0000;
    yexp[2] = 32'h4040_0000; yexp[3] = 32'h4080_0000;

    rst = 1'b1; inj_rdy = 1'b0;
    req_valid = '0; drain_req = 1'b0;
    req_valid_s = '0; drain_req_s = 1'b0;
    req_x   = {xop[3], xop[2], xop[1], xop[0]};
    req_x_s = {xop[3], xop[2], xop[1], xop[0]};

    // Reset values, then flush window with a held request and an injected log_rdy.
    tick; tick;
    chk("rst_req_ack", req_ack, 0);
    chk("rst_log_valid", log_valid, 0);
    chk("rst_log_x", log_x, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_err", err_underflow, 0);
    rst = 1'b0;
    req_valid = 4'b0001;
    bad = 1'b0; bad2 = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      inj_rdy = (k == 10);
      tick;
      if (req_ack != 0 || log_valid) bad = 1'b1;
      if (resp_valid != 0 || err_underflow) bad2 = 1'b1;
    end
    inj_rdy = 1'b0;
    chk("flush_no_grant", bad, 0);
    chk("flush_rdy_discarded", bad2, 0);
    tick;
    chk("flush_exit_ack", req_ack, 4'b0001);
    chk("flush_exit_log_valid", log_valid, 1);
    chk("flush_exit_log_x", log_x, xop[0]);
    req_valid = '0;
    got = 0; rv = '0; rres = '0;
    for (int n = 1; n <= 60; n++) begin
      tick;
      if (resp_valid != 0 && got == 0) begin
        got = n; rv = resp_valid; rres = resp_result;
      end
    end
    chk("first_resp_latency", got, 49);
    chk("first_resp_port", rv, 4'b0001);
    chk("first_resp_value", rres, 32'h3F80_0000);

    // Round robin with all four requesters held high.
    rst = 1'b1; tick; rst = 1'b0;
    repeat (LAT) tick;
    req_valid = 4'b1111;
    bad = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick;
      chk($sformatf("rr_ack_%0d", t), req_ack, 1 << ((t - 1) % 4));
      if (!log_valid || log_x !== xop[(t - 1) % 4]) bad = 1'b1;
    end
    req_valid = '0;
    chk("rr_log_stream", bad, 0);
    n_resp = 0; bad = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      tick;
      if (resp_valid != 0) begin
        if (resp_valid !== (4'b0001 << (n_resp % 4)) || resp_result !== yexp[n_resp % 4]) bad = 1'b1;
        n_resp++;
      end
    end
    chk("rr_resp_order", bad, 0);
    chk("rr_resp_count", n_resp, 12);

    // Credit limit on the TAG_DEPTH=4 instance.
    req_valid_s = 4'b1111;
    n_resp = 0;
    for (int t = 1; t <= 160; t++) begin
      tick;
      if (t <= 60) begin
        ea = 0;
        if (t <= 4) ea = 1 << (t - 1);
        else if (t >= 51 && t <= 54) ea = 1 << (t - 51);
        chk($sformatf("credit_ack_%0d", t), req_ack_s, ea);
      end
      if (t == 60) req_valid_s = '0;
      if (resp_valid_s != 0) n_resp++;
    end
    chk("credit_resp_count", n_resp, 8);

    // Drain with ten in flight, then resume.
    req_valid = 4'b1111;
    n_resp = 0; bad = 1'b0;
    for (int t = 1; t <= 120; t++) begin
      tick;
      if (t <= 10) chk($sformatf("drain_ack_%0d", t), req_ack, 1 << ((t - 1) % 4));
      else if (t <= 63 && req_ack != 0) bad = 1'b1;
      if (t <= 60 && resp_valid != 0) n_resp++;
      if (t == 9) drain_req = 1'b1;
      if (t == 59) begin
        chk("drain_last_resp", resp_valid, 4'b0010);
        chk("drain_done_early", drain_done, 0);
      end
      if (t == 60) chk("drain_done_rise", drain_done, 1);
      if (t == 62) drain_req = 1'b0;
      if (t == 63) chk("drain_done_fall", drain_done, 0);
      if (t == 64) begin
        chk("drain_resume_ack", req_ack, 4'b0100);
        req_valid = '0;
      end
      if (t == 113) begin
        chk("x8_resp_port", resp_valid, 4'b0100);
        chk("x8_resp_value", resp_result, 32'h4040_0000);
      end
    end
    chk("drain_no_ack", bad, 0);
    chk("drain_resp_count", n_resp, 10);

    // Spurious log_rdy with an empty tag FIFO.
    inj_rdy = 1'b1;
    tick;
    inj_rdy = 1'b0;
    chk("underflow_set", err_underflow, 1);
    chk("underflow_no_resp", resp_valid, 0);
    repeat (5) tick;
    chk("underflow_sticky", err_underflow, 1);

    // Reset mid-burst with twenty in flight.
    rst = 1'b1; tick;
    chk("underflow_cleared", err_underflow, 0);
    rst = 1'b0;
    repeat (LAT) tick;
    req_valid = 4'b1111;
    repeat (20) tick;
    req_valid = '0;
    repeat (5) tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk("midrst_outputs", {req_ack, log_valid, resp_valid, drain_done, err_underflow}, 0);
    chk("midrst_data", {log_x, resp_result}, 0);
    n_rdy = 0; bad = 1'b0;
    for (int t = 1; t <= LAT; t++) begin
      tick;
      if (log_rdy) n_rdy++;
      if (resp_valid != 0 || err_underflow || req_ack != 0) bad = 1'b1;
    end
    chk("midrst_stale_rdy_seen", n_rdy, 20);
    chk("midrst_stale_discarded", bad, 0);
    req_valid = 4'b0001;
    tick;
    chk("midrst_new_ack", req_ack, 4'b0001);
    req_valid = '0;
    got = 0; rv = '0; rres = '0;
    for (int n = 1; n <= 60; n++) begin
      tick;
      if (resp_valid != 0 && got == 0) begin
        got = n; rv = resp_valid; rres = resp_result;
      end
    end
    chk("midrst_resp_latency", got, 49);
    chk("midrst_resp_port", rv, 4'b0001);
    chk("midrst_resp_value", rres, 32'h3F80_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
